// File: rtl/rst_seq_pkg.sv
// Shared types for the reset sequencer: FSM state and last-reset-cause encoding.
// No logic; imported by rst_seq_sys.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        HOLD   = 2'd0,
        PERIPH = 2'd1,
        RUN    = 2'd2,
        SWRST  = 2'd3
    } rst_seq_state_e;

    typedef enum logic [1:0] {
        RST_CAUSE_PIN  = 2'b01,
        RST_CAUSE_LOCK = 2'b10,
        RST_CAUSE_SW   = 2'b11
    } rst_cause_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_nff.sv
// N-stage flop synchroniser with async active-low clear to 0; latency N edges.
// No backpressure: free-running sampler.
module sync_nff #(
    parameter int N = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d,
    output logic q
);

    logic [N-1:0] sr;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sr <= '0;
        end else begin
            sr <= {sr[N-2:0], d};
        end
    end

    assign q = sr[N-1];

endmodule

// File: rtl/rst_seq_sys.sv
// Staged reset sequencer: peripherals released SYNC_STAGES+HOLD_CYCLES edges after reset/lock, core CORE_DELAY later.
// No backpressure: lock loss and software requests force both resets low on the next edge.
module rst_seq_sys
    import rst_seq_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int HOLD_CYCLES   = 16,
    parameter int CORE_DELAY    = 8,
    parameter int SW_RST_CYCLES = 16
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       pll_locked_i,
    input  logic       sw_rst_req_i,
    output logic       rst_periph_no,
    output logic       rst_core_no,
    output logic       rst_done_o,
    output logic [1:0] rst_cause_o
);

    localparam int CNT_MAX = max3(HOLD_CYCLES, CORE_DELAY, SW_RST_CYCLES);
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] CORE_LAST = CW'(CORE_DELAY - 1);
    localparam logic [CW-1:0] SW_LAST   = CW'(SW_RST_CYCLES - 1);

    logic           rst_s;
    logic           lock_s;
    rst_seq_state_e state;
    logic [CW-1:0]  cnt;
    logic           periph_q;
    logic           core_q;
    rst_cause_e     cause_q;

    sync_nff #(.N(SYNC_STAGES)) u_sync_rst (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d      (1'b1),
        .q      (rst_s)
    );

    sync_nff #(.N(SYNC_STAGES)) u_sync_lock (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d      (pll_locked_i),
        .q      (lock_s)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= HOLD;
            cnt      <= '0;
            periph_q <= 1'b0;
            core_q   <= 1'b0;
            cause_q  <= RST_CAUSE_PIN;
        end else if (state == HOLD) begin
            // Any unlocked edge restarts the hold window; cause is left alone here.
            if (!lock_s) begin
                cnt <= '0;
            end else if (rst_s) begin
                if (cnt == HOLD_LAST) begin
                    state    <= PERIPH;
                    periph_q <= 1'b1;
                    cnt      <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end else if (!lock_s) begin
            // Lock loss outranks a software request seen on the same edge.
            state    <= HOLD;
            periph_q <= 1'b0;
            core_q   <= 1'b0;
            cnt      <= '0;
            cause_q  <= RST_CAUSE_LOCK;
        end else begin
            unique case (state)
                PERIPH: begin
                    if (cnt == CORE_LAST) begin
                        state  <= RUN;
                        core_q <= 1'b1;
                        cnt    <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (sw_rst_req_i) begin
                        state    <= SWRST;
                        periph_q <= 1'b0;
                        core_q   <= 1'b0;
                        cnt      <= '0;
                        cause_q  <= RST_CAUSE_SW;
                    end
                end
                SWRST: begin
                    if (cnt == SW_LAST) begin
                        state <= HOLD;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= HOLD;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign rst_periph_no = periph_q;
    assign rst_core_no   = core_q;
    assign rst_done_o    = core_q;
    assign rst_cause_o   = cause_q;

endmodule

// File: tb/tb_rst_seq_sys.sv
// Scenario bench for rst_seq_sys: expected release latencies are queued when stimulus is applied
// and popped when the corresponding reset output is seen rising.
module tb_rst_seq_sys;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       pll_locked_i;
    logic       sw_rst_req_i;
    logic       rst_periph_no;
    logic       rst_core_no;
    logic       rst_done_o;
    logic [1:0] rst_cause_o;

    int tests_run    = 0;
    int tests_failed = 0;
    int exp_q[$];

    rst_seq_sys dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .pll_locked_i  (pll_locked_i),
        .sw_rst_req_i  (sw_rst_req_i),
        .rst_periph_no (rst_periph_no),
        .rst_core_no   (rst_core_no),
        .rst_done_o    (rst_done_o),
        .rst_cause_o   (rst_cause_o)
    );

    always #5 clk_i = ~clk_i;

    // Advance k rising edges, leaving time just after the last edge.
    task automatic step(input int k);
        repeat (k) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    // Edges until the selected reset output is seen high; -1 if the budget expires.
    task automatic count_until(input bit use_core, input int budget, output int n);
        bit seen;
        seen = 1'b0;
        n = -1;
        for (int i = 1; i <= budget && !seen; i++) begin
            @(posedge clk_i);
            #1;
            if ((use_core ? rst_core_no : rst_periph_no) === 1'b1) begin
                seen = 1'b1;
                n = i;
            end
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        pll_locked_i = 1'b1;
        sw_rst_req_i = 1'b0;
        step(3);
        tests_run++;
        if (rst_periph_no !== 1'b0) begin tests_failed++; $display("FAIL reset_periph: got %b want 0", rst_periph_no); end
        tests_run++;
        if (rst_core_no !== 1'b0) begin tests_failed++; $display("FAIL reset_core: got %b want 0", rst_core_no); end
        tests_run++;
        if (rst_done_o !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b want 0", rst_done_o); end
        tests_run++;
        if (rst_cause_o !== 2'b01) begin tests_failed++; $display("FAIL reset_cause: got %b want 01", rst_cause_o); end
    endtask

    task automatic test_power_up();
        int n, n2, e;
        exp_q.push_back(18);
        exp_q.push_back(26);
        rst_ni = 1'b1;
        count_until(1'b0, 100, n);
        e = exp_q.pop_front();
        tests_run++;
        if (n !== e) begin tests_failed++; $display("FAIL pwr_periph_lat: got %0d want %0d", n, e); end
        count_until(1'b1, 100, n2);
        e = exp_q.pop_front();
        tests_run++;
        if (n + n2 !== e) begin tests_failed++; $display("FAIL pwr_core_lat: got %0d want %0d", n + n2, e); end
        tests_run++;
        if (rst_done_o !== 1'b1) begin tests_failed++; $display("FAIL pwr_done: got %b want 1", rst_done_o); end
        tests_run++;
        if (rst_cause_o !== 2'b01) begin tests_failed++; $display("FAIL pwr_cause: got %b want 01", rst_cause_o); end
    endtask

    task automatic test_late_lock();
        int n, e;
        rst_ni = 1'b0;
        pll_locked_i = 1'b0;
        step(2);
        rst_ni = 1'b1;
        step(10);
        tests_run++;
        if (rst_periph_no !== 1'b0) begin tests_failed++; $display("FAIL late_no_lock_periph: got %b want 0", rst_periph_no); end
        pll_locked_i = 1'b1;
        exp_q.push_back(18);
        count_until(1'b0, 100, n);
        e = exp_q.pop_front();
        tests_run++;
        if (n !== e) begin tests_failed++; $display("FAIL late_lock_lat: got %0d want %0d", n, e); end

        // One-cycle lock dropout while holding must restart the window.
        rst_ni = 1'b0;
        step(2);
        rst_ni = 1'b1;
        step(8);
        pll_locked_i = 1'b0;
        step(1);
        pll_locked_i = 1'b1;
        exp_q.push_back(18);
        exp_q.push_back(8);
        count_until(1'b0, 100, n);
        e = exp_q.pop_front();
        tests_run++;
        if (n !== e) begin tests_failed++; $display("FAIL glitch_restart_lat: got %0d want %0d", n, e); end
        tests_run++;
        if (rst_cause_o !== 2'b01) begin tests_failed++; $display("FAIL glitch_cause: got %b want 01", rst_cause_o); end
        count_until(1'b1, 100, n);
        e = exp_q.pop_front();
        tests_run++;
        if (n !== e) begin tests_failed++; $display("FAIL glitch_core_lat: got %0d want %0d", n, e); end
    endtask

    task automatic test_sw_reset();
        int n, n2, e;
        sw_rst_req_i = 1'b1;
        step(1);
        sw_rst_req_i = 1'b0;
        exp_q.push_back(32);
        exp_q.push_back(40);
        tests_run++;
        if (rst_periph_no !== 1'b0) begin tests_failed++; $display("FAIL sw_periph_low: got %b want 0", rst_periph_no); end
        tests_run++;
        if (rst_core_no !== 1'b0) begin tests_failed++; $display("FAIL sw_core_low: got %b want 0", rst_core_no); end
        tests_run++;
        if (rst_done_o !== 1'b0) begin tests_failed++; $display("FAIL sw_done_low: got %b want 0", rst_done_o); end
        tests_run++;
        if (rst_cause_o !== 2'b11) begin tests_failed++; $display("FAIL sw_cause: got %b want 11", rst_cause_o); end
        count_until(1'b0, 100, n);
        e = exp_q.pop_front();
        tests_run++;
        if (n !== e) begin tests_failed++; $display("FAIL sw_periph_lat: got %0d want %0d", n, e); end
        count_until(1'b1, 100, n2);
        e = exp_q.pop_front();
        tests_run++;
        if (n + n2 !== e) begin tests_failed++; $display("FAIL sw_core_lat: got %0d want %0d", n + n2, e); end
        tests_run++;
        if (rst_cause_o !== 2'b11) begin tests_failed++; $display("FAIL sw_cause_persist: got %b want 11", rst_cause_o); end
    endtask

    task automatic test_lock_loss_sw();
        int n, n2, e;
        pll_locked_i = 1'b0;
        step(2);
        tests_run++;
        if (rst_core_no !== 1'b1) begin tests_failed++; $display("FAIL ll_still_run: got %b want 1", rst_core_no); end
        sw_rst_req_i = 1'b1;
        step(1);
        tests_run++;
        if (rst_periph_no !== 1'b0 || rst_core_no !== 1'b0 || rst_done_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL ll_resets_low: got periph=%b core=%b done=%b want 000", rst_periph_no, rst_core_no, rst_done_o);
        end
        tests_run++;
        if (rst_cause_o !== 2'b10) begin tests_failed++; $display("FAIL ll_cause: got %b want 10", rst_cause_o); end
        step(5);
        sw_rst_req_i = 1'b0;
        step(20);
        tests_run++;
        if (rst_periph_no !== 1'b0) begin tests_failed++; $display("FAIL ll_held_while_unlocked: got %b want 0", rst_periph_no); end
        pll_locked_i = 1'b1;
        exp_q.push_back(18);
        exp_q.push_back(26);
        count_until(1'b0, 100, n);
        e = exp_q.pop_front();
        tests_run++;
        if (n !== e) begin tests_failed++; $display("FAIL ll_periph_lat: got %0d want %0d", n, e); end
        count_until(1'b1, 100, n2);
        e = exp_q.pop_front();
        tests_run++;
        if (n + n2 !== e) begin tests_failed++; $display("FAIL ll_core_lat: got %0d want %0d", n + n2, e); end
        tests_run++;
        if (rst_cause_o !== 2'b10) begin tests_failed++; $display("FAIL ll_cause_persist: got %b want 10", rst_cause_o); end
    endtask

    task automatic test_back_to_back();
        int n, n2, e;
        sw_rst_req_i = 1'b1;
        step(1);
        exp_q.push_back(40);
        tests_run++;
        if (rst_core_no !== 1'b0) begin tests_failed++; $display("FAIL b2b_first_low: got %b want 0", rst_core_no); end
        count_until(1'b1, 100, n);
        e = exp_q.pop_front();
        tests_run++;
        if (n !== e) begin tests_failed++; $display("FAIL b2b_first_release: got %0d want %0d", n, e); end
        step(1);
        tests_run++;
        if (rst_core_no !== 1'b0 || rst_cause_o !== 2'b11) begin
            tests_failed++;
            $display("FAIL b2b_retrigger: got core=%b cause=%b want core=0 cause=11", rst_core_no, rst_cause_o);
        end
        sw_rst_req_i = 1'b0;
        exp_q.push_back(32);
        exp_q.push_back(40);
        count_until(1'b0, 100, n);
        e = exp_q.pop_front();
        tests_run++;
        if (n !== e) begin tests_failed++; $display("FAIL b2b_periph_lat: got %0d want %0d", n, e); end
        count_until(1'b1, 100, n2);
        e = exp_q.pop_front();
        tests_run++;
        if (n + n2 !== e) begin tests_failed++; $display("FAIL b2b_core_lat: got %0d want %0d", n + n2, e); end
    endtask

    task automatic test_async_mid_swrst();
        int n, n2, e;
        sw_rst_req_i = 1'b1;
        step(1);
        sw_rst_req_i = 1'b0;
        step(5);
        tests_run++;
        if (rst_cause_o !== 2'b11) begin tests_failed++; $display("FAIL async_pre_cause: got %b want 11", rst_cause_o); end
        #2;
        rst_ni = 1'b0;
        #1;
        tests_run++;
        if (rst_periph_no !== 1'b0 || rst_core_no !== 1'b0 || rst_done_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_resets_low: got periph=%b core=%b done=%b want 000", rst_periph_no, rst_core_no, rst_done_o);
        end
        tests_run++;
        if (rst_cause_o !== 2'b01) begin tests_failed++; $display("FAIL async_cause: got %b want 01", rst_cause_o); end
        step(1);
        rst_ni = 1'b1;
        exp_q.push_back(18);
        exp_q.push_back(26);
        count_until(1'b0, 100, n);
        e = exp_q.pop_front();
        tests_run++;
        if (n !== e) begin tests_failed++; $display("FAIL async_periph_lat: got %0d want %0d", n, e); end
        count_until(1'b1, 100, n2);
        e = exp_q.pop_front();
        tests_run++;
        if (n + n2 !== e) begin tests_failed++; $display("FAIL async_core_lat: got %0d want %0d", n + n2, e); end
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_late_lock();
        test_sw_reset();
        test_lock_loss_sw();
        test_back_to_back();
        test_async_mid_swrst();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
